// File: rtl/rv32i_types.sv
// Shared types for the branch predictor update path: 2-bit counter states and
// the per-branch record kept between fetch and resolution.
package rv32i_types;

  typedef enum logic [1:0] {
    snt = 2'b00,
    wnt = 2'b01,
    wt  = 2'b10,
    st  = 2'b11
  } prediction_t;

  localparam int unsigned PastBranchBits = 2;

  typedef struct packed {
    logic [31:0]               pc;
    prediction_t               prediction;
    logic [31:0]               target;
    logic [PastBranchBits-1:0] hist;
  } branch_record_t;

  function automatic logic pred_taken(input prediction_t p);
    return (p == wt) || (p == st);
  endfunction

endpackage

// File: rtl/branch_resolution_queue_if.sv
// Fetch/execute/predictor-facing signals of the branch resolution queue.
interface branch_resolution_queue_if #(
    parameter int unsigned PAST_BRANCH_BITS = 2
);
  import rv32i_types::*;

  logic                        push;
  logic [31:0]                 push_pc;
  prediction_t                 push_prediction;
  logic [31:0]                 push_target;
  logic                        full;
  logic                        resolve;
  logic                        resolve_taken;
  logic [31:0]                 resolve_target;
  logic [PAST_BRANCH_BITS-1:0] spec_history;
  logic                        update;
  logic                        correct;
  logic [31:0]                 pc_update;
  prediction_t                 previous_prediction;
  logic [31:0]                 calculated_target;
  logic [PAST_BRANCH_BITS-1:0] update_history;
  logic                        flush;
  logic [31:0]                 redirect_pc;

  modport master (
    output push, push_pc, push_prediction, push_target,
    output resolve, resolve_taken, resolve_target,
    input  full, spec_history, update, correct, pc_update, previous_prediction,
    input  calculated_target, update_history, flush, redirect_pc
  );

  modport slave (
    input  push, push_pc, push_prediction, push_target,
    input  resolve, resolve_taken, resolve_target,
    output full, spec_history, update, correct, pc_update, previous_prediction,
    output calculated_target, update_history, flush, redirect_pc
  );

endinterface

// File: rtl/branch_record_fifo.sv
// Circular buffer with wrap-bit pointers; push is allowed when full if a pop
// happens on the same edge. clear empties the queue and wins over push/pop.
module branch_record_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  always_comb begin
    full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    empty    = (wr_ptr_q == rd_ptr_q);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    pop_data = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/branch_resolution_queue.sv
// Tracks predicted branches until execute resolves them, drives the predictor
// update port, and on a mispredict flushes, redirects and repairs history.
module branch_resolution_queue
  import rv32i_types::*;
#(
    parameter int unsigned DEPTH            = 8,
    parameter int unsigned PAST_BRANCH_BITS = 2
) (
    input logic                       clk,
    input logic                       rst,
    branch_resolution_queue_if.slave  bq
);
  localparam int unsigned HB = PAST_BRANCH_BITS;
  localparam int unsigned RW = $bits(branch_record_t);

  branch_record_t head, push_rec;
  logic [RW-1:0]  head_bits;
  logic           empty, full;
  logic           resolve_ok, push_req, push_ok, correct_c, mispredict, clear;
  logic [HB-1:0]  spec_history_q, spec_history_d;

  logic           update_q, correct_q, flush_q;
  logic [31:0]    pc_update_q, calc_target_q, redirect_q;
  prediction_t    prev_pred_q;
  logic [HB-1:0]  update_history_q;

  always_comb begin
    head       = branch_record_t'(head_bits);
    resolve_ok = bq.resolve && !empty;
    correct_c  = pred_taken(head.prediction) == bq.resolve_taken;
    mispredict = !correct_c || (bq.resolve_taken && (bq.resolve_target != head.target));
    clear      = resolve_ok && mispredict;
    // Pushes in the flush cycle or alongside a mispredict are wrong-path.
    push_req   = bq.push && !flush_q && !clear;
    push_ok    = push_req && (!full || resolve_ok);

    push_rec.pc         = bq.push_pc;
    push_rec.prediction = bq.push_prediction;
    push_rec.target     = bq.push_target;
    push_rec.hist       = PastBranchBits'(spec_history_q);

    spec_history_d = spec_history_q;
    if (clear) begin
      spec_history_d = HB'({HB'(head.hist), bq.resolve_taken});
    end else if (push_ok) begin
      spec_history_d = HB'({spec_history_q, pred_taken(bq.push_prediction)});
    end
  end

  branch_record_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push_req),
    .push_data (push_rec),
    .pop       (resolve_ok),
    .pop_data  (head_bits),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spec_history_q   <= '0;
      update_q         <= 1'b0;
      correct_q        <= 1'b0;
      flush_q          <= 1'b0;
      pc_update_q      <= '0;
      calc_target_q    <= '0;
      redirect_q       <= '0;
      prev_pred_q      <= snt;
      update_history_q <= '0;
    end else begin
      spec_history_q <= spec_history_d;
      update_q       <= resolve_ok;
      flush_q        <= clear;
      if (resolve_ok) begin
        correct_q        <= correct_c;
        pc_update_q      <= head.pc;
        prev_pred_q      <= head.prediction;
        calc_target_q    <= bq.resolve_taken ? bq.resolve_target : head.target;
        update_history_q <= HB'(head.hist);
      end
      if (clear) redirect_q <= bq.resolve_taken ? bq.resolve_target : head.pc + 32'd4;
    end
  end

  assign bq.full                = full;
  assign bq.spec_history        = spec_history_q;
  assign bq.update              = update_q;
  assign bq.correct             = correct_q;
  assign bq.pc_update           = pc_update_q;
  assign bq.previous_prediction = prev_pred_q;
  assign bq.calculated_target   = calc_target_q;
  assign bq.update_history      = update_history_q;
  assign bq.flush               = flush_q;
  assign bq.redirect_pc         = redirect_q;

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Directed vector table, full/wrap and reset sequences, then random traffic,
// all checked against a queue-based reference model.
module tb_branch_resolution_queue;
  import rv32i_types::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PB    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_resolution_queue_if #(.PAST_BRANCH_BITS(PB)) bq ();

  branch_resolution_queue #(
    .DEPTH            (DEPTH),
    .PAST_BRANCH_BITS (PB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bq  (bq)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  branch_record_t mq[$];
  logic [PB-1:0]  m_hist;
  logic           m_update, m_correct, m_flush;
  logic [31:0]    m_pc, m_tgt, m_redir;
  prediction_t    m_pred;
  logic [PB-1:0]  m_uhist;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_hist = '0; m_update = 0; m_correct = 0; m_flush = 0;
    m_pc = '0; m_tgt = '0; m_redir = '0; m_pred = snt; m_uhist = '0;
  endtask

  task automatic model_step(input logic p, input logic [31:0] pc, input prediction_t pr,
                            input logic [31:0] t, input logic r, input logic rt,
                            input logic [31:0] rtg);
    branch_record_t e, n;
    logic [PB-1:0]  old_hist = m_hist;
    bit res_ok  = r && (mq.size() != 0);
    bit push_ok = p && !m_flush && ((mq.size() < DEPTH) || res_ok);
    bit mis     = 0;
    m_update = 0;
    if (res_ok) begin
      e         = mq.pop_front();
      m_correct = ((e.prediction == wt) || (e.prediction == st)) == rt;
      mis       = !m_correct || (rt && (rtg != e.target));
      m_update  = 1;
      m_pc      = e.pc;
      m_pred    = e.prediction;
      m_tgt     = rt ? rtg : e.target;
      m_uhist   = e.hist;
      if (mis) begin
        mq.delete();
        m_redir = rt ? rtg : e.pc + 32'd4;
        m_hist  = PB'({e.hist, rt});
        push_ok = 0;
      end
    end
    if (push_ok) begin
      n.pc = pc; n.prediction = pr; n.target = t; n.hist = old_hist;
      mq.push_back(n);
      m_hist = PB'({old_hist, (pr == wt) || (pr == st)});
    end
    m_flush = mis;
  endtask

  task automatic compare_model();
    chk("full", 32'(bq.full), 32'(mq.size() == DEPTH));
    chk("spec_history", 32'(bq.spec_history), 32'(m_hist));
    chk("update", 32'(bq.update), 32'(m_update));
    chk("flush", 32'(bq.flush), 32'(m_flush));
    chk("correct", 32'(bq.correct), 32'(m_correct));
    chk("pc_update", bq.pc_update, m_pc);
    chk("previous_prediction", 32'(bq.previous_prediction), 32'(m_pred));
    chk("calculated_target", bq.calculated_target, m_tgt);
    chk("update_history", 32'(bq.update_history), 32'(m_uhist));
    chk("redirect_pc", bq.redirect_pc, m_redir);
  endtask

  task automatic cycle(input logic p, input logic [31:0] pc, input prediction_t pr,
                       input logic [31:0] t, input logic r, input logic rt,
                       input logic [31:0] rtg);
    bq.push = p; bq.push_pc = pc; bq.push_prediction = pr; bq.push_target = t;
    bq.resolve = r; bq.resolve_taken = rt; bq.resolve_target = rtg;
    model_step(p, pc, pr, t, r, rt, rtg);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic        p;
    logic [31:0] pc;
    prediction_t pr;
    logic [31:0] t;
    logic        r;
    logic        rt;
    logic [31:0] rtg;
    logic        e_upd;
    logic        e_cor;
    logic        e_fl;
    logic [31:0] e_pc;
    logic [31:0] e_tgt;
    logic [31:0] e_redir;
    logic [1:0]  e_hist;
  } vec_t;

  vec_t vt[12];
  logic [31:0] exp_pc[$];

  initial begin
    // p   pc       pr   t        r  rt rtg      upd cor fl  pc      tgt     redir   hist
    vt[0]  = '{1, 32'h100, st,  32'h200, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h0,  32'h0,  2'b01};
    vt[1]  = '{0, 32'h0,   snt, 32'h0,   1, 1, 32'h200, 1, 1, 0, 32'h100,32'h200,32'h0,  2'b01};
    vt[2]  = '{1, 32'h40,  wt,  32'h80,  0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h0,  32'h0,  2'b11};
    vt[3]  = '{0, 32'h0,   snt, 32'h0,   1, 0, 32'h0,   1, 0, 1, 32'h40, 32'h80, 32'h44, 2'b10};
    vt[4]  = '{0, 32'h0,   snt, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h0,  32'h0,  2'b10};
    vt[5]  = '{1, 32'h10,  st,  32'h20,  0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h0,  32'h0,  2'b01};
    vt[6]  = '{0, 32'h0,   snt, 32'h0,   1, 1, 32'h30,  1, 1, 1, 32'h10, 32'h30, 32'h30, 2'b01};
    vt[7]  = '{1, 32'h500, st,  32'h600, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h0,  32'h0,  2'b01};
    vt[8]  = '{0, 32'h0,   snt, 32'h0,   1, 1, 32'h600, 0, 0, 0, 32'h0,  32'h0,  32'h0,  2'b01};
    vt[9]  = '{1, 32'h60,  snt, 32'h64,  0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h0,  32'h0,  2'b10};
    vt[10] = '{1, 32'h70,  st,  32'h90,  1, 1, 32'h68,  1, 0, 1, 32'h60, 32'h68, 32'h68, 2'b11};
    vt[11] = '{0, 32'h0,   snt, 32'h0,   1, 1, 32'h90,  0, 0, 0, 32'h0,  32'h0,  32'h0,  2'b11};

    bq.push = 0; bq.push_pc = '0; bq.push_prediction = snt; bq.push_target = '0;
    bq.resolve = 0; bq.resolve_taken = 0; bq.resolve_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_full", 32'(bq.full), 32'h0);
    chk("reset_hist", 32'(bq.spec_history), 32'h0);
    chk("reset_prev_pred", 32'(bq.previous_prediction), 32'(snt));
    compare_model();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      cycle(vt[i].p, vt[i].pc, vt[i].pr, vt[i].t, vt[i].r, vt[i].rt, vt[i].rtg);
      chk($sformatf("vec%0d_update", i), 32'(bq.update), 32'(vt[i].e_upd));
      chk($sformatf("vec%0d_flush", i), 32'(bq.flush), 32'(vt[i].e_fl));
      chk($sformatf("vec%0d_hist", i), 32'(bq.spec_history), 32'(vt[i].e_hist));
      if (vt[i].e_upd) begin
        chk($sformatf("vec%0d_correct", i), 32'(bq.correct), 32'(vt[i].e_cor));
        chk($sformatf("vec%0d_pc_update", i), bq.pc_update, vt[i].e_pc);
        chk($sformatf("vec%0d_calc_target", i), bq.calculated_target, vt[i].e_tgt);
      end
      if (vt[i].e_fl) chk($sformatf("vec%0d_redirect", i), bq.redirect_pc, vt[i].e_redir);
    end

    // Fill to full across the pointer wrap, overflow push, push+pop while full, drain.
    for (int i = 0; i < 8; i++) begin
      cycle(1, 32'h1000 + 32'(i * 4), st, 32'h1100 + 32'(i * 4), 0, 0, 32'h0);
      if (i > 0) exp_pc.push_back(32'h1000 + 32'(i * 4));
    end
    chk("full_after_8", 32'(bq.full), 32'h1);
    cycle(1, 32'h2000, st, 32'h2100, 0, 0, 32'h0);
    chk("full_after_overflow", 32'(bq.full), 32'h1);
    cycle(1, 32'h3000, st, 32'h3100, 1, 1, 32'h1100);
    exp_pc.push_back(32'h3000);
    chk("full_push_pop", 32'(bq.full), 32'h1);
    chk("full_push_pop_pc", bq.pc_update, 32'h1000);
    chk("full_push_pop_flush", 32'(bq.flush), 32'h0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 32'h0, snt, 32'h0, 1, 1, exp_pc[i] + 32'h100);
      chk($sformatf("drain%0d_pc", i), bq.pc_update, exp_pc[i]);
      chk($sformatf("drain%0d_update", i), 32'(bq.update), 32'h1);
    end
    chk("drained_full", 32'(bq.full), 32'h0);

    // Asynchronous reset mid-operation, while an update pulse is showing.
    for (int i = 0; i < 3; i++) cycle(1, 32'h700 + 32'(i * 4), st, 32'h800, 0, 0, 32'h0);
    cycle(0, 32'h0, snt, 32'h0, 1, 1, 32'h800);
    chk("pre_reset_update", 32'(bq.update), 32'h1);
    rst = 1'b0;
    #1;
    chk("async_reset_full", 32'(bq.full), 32'h0);
    chk("async_reset_hist", 32'(bq.spec_history), 32'h0);
    chk("async_reset_update", 32'(bq.update), 32'h0);
    chk("async_reset_flush", 32'(bq.flush), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle(0, 32'h0, snt, 32'h0, 1, 1, 32'h800);
    chk("resolve_after_reset", 32'(bq.update), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic        p, r, rt;
      logic [31:0] pc, t, rtg;
      prediction_t pr;
      p   = ($urandom_range(0, 9) < 6);
      r   = ($urandom_range(0, 9) < 4);
      rt  = $urandom_range(0, 1);
      pc  = $urandom & 32'hffff_fffc;
      t   = $urandom_range(0, 1) ? pc + 32'd8 : ($urandom & 32'hffff_fffc);
      pr  = prediction_t'($urandom_range(0, 3));
      rtg = (mq.size() != 0 && $urandom_range(0, 3) != 0) ? mq[0].target
                                                           : ($urandom & 32'hffff_fffc);
      cycle(p, pc, pr, t, r, rt, rtg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
